// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full/level logic of an asynchronous FIFO.
// Works in the clk domain against a read pointer that has already been synchronised into it.
module fifo_wptr_full #(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic                  ovf_clr,
    input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  wr_ack,
    output logic                  overflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] next_bin;
    logic [PW-1:0] next_gray;
    logic [PW-1:0] rbin_sync;
    logic [PW-1:0] next_level;
    logic [PW-1:0] full_pattern;
    logic          accept;
    logic          next_full;
    logic          next_afull;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Handshake: wr_en is the request and ~wfull the ready; a write transfers
    // only when both are high at a clk edge, and wr_ack reports it one cycle later.
    always_comb begin
        accept       = wr_en & ~wfull;
        next_bin     = wbin + {{(PW-1){1'b0}}, accept};
        next_gray    = next_bin ^ (next_bin >> 1);
        rbin_sync    = gray2bin(rptr_gray_sync);
        next_level   = next_bin - rbin_sync;
        // Full when the pointers differ only in the wrap bit, seen in Gray form.
        full_pattern = {~rptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1], rptr_gray_sync[ADDR_WIDTH-2:0]};
        next_full    = (next_gray == full_pattern);
        next_afull   = (next_level >= AFULL_LVL);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wbin         <= '0;
            wptr_gray    <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            wr_ack       <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            wbin         <= next_bin;
            wptr_gray    <= next_gray;
            wfull        <= next_full;
            walmost_full <= next_afull;
            wlevel       <= next_level;
            wr_ack       <= accept;
            if (wr_en && wfull) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign waddr = wbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Randomised scoreboard bench for fifo_wptr_full: a count-based FIFO model predicts
// every output each cycle; a monitor pops and compares after each rising edge.
module tb_fifo_wptr_full;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int THR   = 12;
    localparam int W     = AW + (AW + 1) + 1 + 1 + (AW + 1) + 1 + 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          wr_en = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [AW:0]   rptr_gray_sync = '0;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr_gray;
    logic          wfull;
    logic          walmost_full;
    logic [AW:0]   wlevel;
    logic          wr_ack;
    logic          overflow;

    fifo_wptr_full #(.ADDR_WIDTH(AW), .AFULL_THRESH(THR)) dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .ovf_clr(ovf_clr),
        .rptr_gray_sync(rptr_gray_sync), .waddr(waddr), .wptr_gray(wptr_gray),
        .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel),
        .wr_ack(wr_ack), .overflow(overflow)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    logic mon_en = 1'b0;
    logic gray_prev_valid = 1'b0;
    logic [AW:0] gray_prev;

    // reference model: counts of writes accepted and entries read since reset
    int   wcount = 0;
    int   rcount = 0;
    logic m_full = 1'b0;
    logic m_ovf  = 1'b0;

    function automatic logic [AW:0] to_gray(input int v);
        logic [AW:0] b;
        b = (AW+1)'(v % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] expect_vec(input logic ack);
        int lvl;
        lvl = wcount - rcount;
        return {(AW)'(wcount % DEPTH), to_gray(wcount), m_full, (lvl >= THR),
                (AW+1)'(lvl), ack, m_ovf};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_waddr"}, int'(waddr), 0);
        check({tag, "_wptr_gray"}, int'(wptr_gray), 0);
        check({tag, "_wfull"}, int'(wfull), 0);
        check({tag, "_walmost_full"}, int'(walmost_full), 0);
        check({tag, "_wlevel"}, int'(wlevel), 0);
        check({tag, "_wr_ack"}, int'(wr_ack), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
    endtask

    // driver: one clock cycle of stimulus plus the model's prediction for the next edge
    task automatic cycle(input logic wr, input logic clr, input int rc);
        logic acc;
        @(negedge clk);
        wr_en = wr;
        ovf_clr = clr;
        rcount = rc;
        rptr_gray_sync = to_gray(rc);
        acc = wr && !m_full;
        if (wr && m_full) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        wcount += int'(acc);
        m_full = ((wcount - rcount) == DEPTH);
        exp_q.push_back(expect_vec(acc));
        mon_en = 1'b1;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        wr_en = 1'b0;
        ovf_clr = 1'b0;
        #2 rstn = 1'b0;
        #1 check_zero("midrst");
        wcount = 0;
        rcount = 0;
        m_full = 1'b0;
        m_ovf = 1'b0;
        rptr_gray_sync = '0;
        gray_prev_valid = 1'b0;
        exp_q.push_back(expect_vec(1'b0));
        #1 rstn = 1'b1;
    endtask

    // monitor: every edge is an output event for this block
    always @(posedge clk) begin
        logic [W-1:0] e;
        int flips;
        #1;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                check("queue_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("waddr", int'(waddr), int'(e[W-1 -: AW]));
                check("wptr_gray", int'(wptr_gray), int'(e[W-AW-1 -: AW+1]));
                check("wfull", int'(wfull), int'(e[AW+4]));
                check("walmost_full", int'(walmost_full), int'(e[AW+3]));
                check("wlevel", int'(wlevel), int'(e[AW+2:2]));
                check("wr_ack", int'(wr_ack), int'(e[1]));
                check("overflow", int'(overflow), int'(e[0]));
            end
            if (gray_prev_valid) begin
                flips = $countones(gray_prev ^ wptr_gray);
                check("gray_step_le1", int'(flips <= 1), 1);
            end
            gray_prev = wptr_gray;
            gray_prev_valid = 1'b1;
        end
    end

    initial begin
        int rc;
        // asynchronous reset before any clock edge
        #1 rstn = 1'b0;
        #1 check_zero("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) cycle(1'b0, 1'b0, 0);

        // fill from empty
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 0);
        @(posedge clk);
        #2;
        check("fill_gray_11000", int'(wptr_gray), 24);
        check("fill_wlevel", int'(wlevel), DEPTH);
        check("fill_wfull", int'(wfull), 1);

        // overflow while full, then clear
        repeat (3) cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b1, 0);
        cycle(1'b0, 1'b1, 0);
        cycle(1'b0, 1'b0, 0);

        // drain one entry at a time
        for (int r = 1; r <= DEPTH; r++) cycle(1'b0, 1'b0, r);

        // wrap with the reader two writes behind
        rc = rcount;
        for (int i = 0; i < 40; i++) begin
            if (wcount >= 2 && wcount - 2 > rc) rc = wcount - 2;
            cycle(1'b1, 1'b0, rc);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, wcount);

        // random traffic: writer faster than reader so full/overflow get exercised
        rc = rcount;
        for (int i = 0; i < 250; i++) begin
            if (rc < wcount && $urandom_range(0, 1) == 1) rc++;
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), rc);
        end

        // reset mid-operation after 7 writes
        mid_reset();
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 0);
        mid_reset();
        cycle(1'b1, 1'b0, 0);
        repeat (2) cycle(1'b0, 1'b0, 0);

        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
